// File: rtl/alarm_trigger.sv
// alarm_trigger: compares the running BCD time against the BCD alarm time and
// runs a ring / snooze / stop state machine paced by the 1 Hz tick. All outputs
// are registered so the buzzer and LEDs never see a combinational input path.
module alarm_trigger #(
  parameter int unsigned RING_TIMEOUT = 60,   // seconds of ringing before auto-stop (1..255)
  parameter int unsigned SNOOZE_TICKS = 300,  // seconds of silence per snooze (1..511)
  parameter int unsigned MAX_SNOOZE   = 3,    // snoozes allowed per alarm event (1..15)
  parameter int unsigned BEEP_ON      = 1,    // ticks buzzer high per beep period (1..15)
  parameter int unsigned BEEP_OFF     = 1     // ticks buzzer low per beep period (1..15)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       alarm_enable,
  input  logic       snooze,
  input  logic       stop,
  input  logic [3:0] unit_min,
  input  logic [3:0] tens_min,
  input  logic [3:0] unit_hour,
  input  logic [3:0] tens_hour,
  input  logic [3:0] alarm_unit_min,
  input  logic [3:0] alarm_tens_min,
  input  logic [3:0] alarm_unit_hour,
  input  logic [3:0] alarm_tens_hour,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [3:0] snooze_count,
  output logic       missed
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_e;

  // Parameters narrowed once to counter widths so every compare is width-matched.
  localparam logic [7:0] RING_LIMIT   = 8'(RING_TIMEOUT);
  localparam logic [8:0] SNOOZE_LIMIT = 9'(SNOOZE_TICKS);
  localparam logic [3:0] SNOOZE_MAX   = 4'(MAX_SNOOZE);
  localparam logic [4:0] BEEP_HIGH    = 5'(BEEP_ON);
  localparam logic [4:0] BEEP_PERIOD  = 5'(BEEP_ON + BEEP_OFF);

  state_e     state_q;
  logic [7:0] ring_sec_q;
  logic [8:0] snz_cnt_q;
  logic [4:0] beep_cnt_q;
  logic [3:0] snooze_count_q;
  logic       match_prev_q;
  logic       buzzer_q;
  logic       ringing_q;
  logic       snoozing_q;
  logic       missed_q;

  logic       match;
  logic       trigger;
  logic [7:0] ring_sec_inc;
  logic [8:0] snz_cnt_inc;
  logic [4:0] beep_cnt_d;
  logic       ring_timeout;
  logic       snooze_expire;
  logic       snooze_allowed;

  // Time compare, edge detect and the "would reach limit" terms for the counters.
  always_comb begin
    // NOTE: every signal gets a value before any branch so no latch is inferred.
    beep_cnt_d     = beep_cnt_q + 5'd1;
    if (beep_cnt_d == BEEP_PERIOD) beep_cnt_d = 5'd0;
    match          = ({tens_hour, unit_hour, tens_min, unit_min} ==
                      {alarm_tens_hour, alarm_unit_hour, alarm_tens_min, alarm_unit_min});
    trigger        = match & ~match_prev_q & alarm_enable;
    ring_sec_inc   = ring_sec_q + 8'd1;
    snz_cnt_inc    = snz_cnt_q + 9'd1;
    ring_timeout   = (ring_sec_inc == RING_LIMIT);
    snooze_expire  = (snz_cnt_inc == SNOOZE_LIMIT);
    snooze_allowed = (snooze_count_q < SNOOZE_MAX);
  end

  // State machine with registered outputs; priority is enable > stop > snooze > timers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      ring_sec_q     <= '0;
      snz_cnt_q      <= '0;
      beep_cnt_q     <= '0;
      snooze_count_q <= '0;
      match_prev_q   <= 1'b1;  // equal times at reset release must not look like a new match
      buzzer_q       <= 1'b0;
      ringing_q      <= 1'b0;
      snoozing_q     <= 1'b0;
      missed_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      match_prev_q <= match;
      missed_q     <= 1'b0;
      if (!alarm_enable) begin
        state_q    <= IDLE;
        buzzer_q   <= 1'b0;
        ringing_q  <= 1'b0;
        snoozing_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (trigger) begin
              state_q        <= RINGING;
              snooze_count_q <= '0;
              ring_sec_q     <= '0;
              beep_cnt_q     <= '0;
              ringing_q      <= 1'b1;
              buzzer_q       <= 1'b1;  // beep_cnt=0 is always inside the ON window
            end
          end
          RINGING: begin
            if (stop) begin
              state_q   <= IDLE;
              ringing_q <= 1'b0;
              buzzer_q  <= 1'b0;
            end else if (snooze && snooze_allowed) begin
              state_q        <= SNOOZE;
              snooze_count_q <= snooze_count_q + 4'd1;
              snz_cnt_q      <= '0;
              ringing_q      <= 1'b0;
              snoozing_q     <= 1'b1;
              buzzer_q       <= 1'b0;
            end else if (tick_1hz) begin
              if (ring_timeout) begin
                state_q   <= IDLE;
                ringing_q <= 1'b0;
                buzzer_q  <= 1'b0;
                missed_q  <= 1'b1;
              end else begin
                ring_sec_q <= ring_sec_inc;
                beep_cnt_q <= beep_cnt_d;
                buzzer_q   <= (beep_cnt_d < BEEP_HIGH);
              end
            end
          end
          SNOOZE: begin
            if (stop) begin
              state_q    <= IDLE;
              snoozing_q <= 1'b0;
            end else if (tick_1hz) begin
              if (snooze_expire) begin
                state_q    <= RINGING;
                ring_sec_q <= '0;
                beep_cnt_q <= '0;
                snoozing_q <= 1'b0;
                ringing_q  <= 1'b1;
                buzzer_q   <= 1'b1;
              end else begin
                snz_cnt_q <= snz_cnt_inc;
              end
            end
          end
          default: begin
            state_q    <= IDLE;
            buzzer_q   <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign buzzer       = buzzer_q;
  assign ringing      = ringing_q;
  assign snoozing     = snoozing_q;
  assign snooze_count = snooze_count_q;
  assign missed       = missed_q;

endmodule
